// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 stream distributor: lane count, control states
// and the lane-select type.
package demux_pkg;

    localparam int N_LANES = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] lane_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [N_LANES-1:0] lane_onehot(input lane_sel_t sel);
        lane_onehot = N_LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane: a one-entry holding register with a valid flag and a
// wrapping count of words handed to the consumer.
module demux_lane_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  cnt
);

    logic fire;
    assign fire = valid && ready;

    // The register is cleared on unload so the lane reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (fire) begin
                valid <= 1'b0;
                data  <= '0;
            end
            if (fire)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux_1_4_32_stream.sv
// Registered 1-to-4 stream distributor: each input word is steered by in_sel
// into its own lane register; a stalled lane only blocks words addressed to it.
module demux_1_4_32_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [1:0]         in_sel,
    output logic [N_LANES-1:0] out_valid,
    input  logic [N_LANES-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data_0,
    output logic [DATA_W-1:0]  out_data_1,
    output logic [DATA_W-1:0]  out_data_2,
    output logic [DATA_W-1:0]  out_data_3,
    output logic [CNT_W-1:0]   lane_cnt_0,
    output logic [CNT_W-1:0]   lane_cnt_1,
    output logic [CNT_W-1:0]   lane_cnt_2,
    output logic [CNT_W-1:0]   lane_cnt_3,
    output logic               busy
);

    state_t                             state;
    lane_sel_t                          sel;
    logic [N_LANES-1:0]                 load;
    logic [N_LANES-1:0][DATA_W-1:0]     data_q;
    logic [N_LANES-1:0][CNT_W-1:0]      cnt_q;

    assign sel = in_sel;

    // Gating with enable blocks an accept on the edge where RUN is left.
    assign in_ready = (state == RUN) && enable && (!out_valid[sel] || out_ready[sel]);
    assign load     = (in_valid && in_ready) ? lane_onehot(sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (!enable)
                    state <= DRAIN;
                DRAIN: if (out_valid == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        demux_lane_reg #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .load_data (in_data),
            .ready     (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (data_q[g]),
            .cnt       (cnt_q[g])
        );
    end

    assign out_data_0 = data_q[0];
    assign out_data_1 = data_q[1];
    assign out_data_2 = data_q[2];
    assign out_data_3 = data_q[3];
    assign lane_cnt_0 = cnt_q[0];
    assign lane_cnt_1 = cnt_q[1];
    assign lane_cnt_2 = cnt_q[2];
    assign lane_cnt_3 = cnt_q[3];

endmodule
